// File: rtl/slot_alloc_arb_pkg.sv
// Shared types and constants for the slot allocator.
// Holds the 64-bit address type and the free-path error codes.
// No logic; imported by the allocator top and its arbiter.
package slot_alloc_arb_pkg;

  typedef logic [63:0] addr_t;

  // Classification of a free request, decoded in the same cycle it arrives.
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_RANGE  = 2'd1;
  localparam logic [1:0] ERR_DOUBLE = 2'd2;

endpackage

// File: rtl/slot_alloc_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at/after the pointer.
// Latency: grant is combinational; the pointer moves on the clock edge after adv_i.
// Ports: req_i request vector, adv_i accept-this-grant, gnt_o one-hot grant.
module rr_arbiter
  import slot_alloc_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Scan N positions starting at the pointer; the first hit wins and the
  // pointer candidate becomes the slot just after the winner.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      idx = PW'((int'(ptr_q) + off) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/slot_alloc_arb.sv
// Slot allocator: round-robin grants of the lowest free slot, plus checked frees.
// Latency: req_ready combinational, rsp/err/count registered one cycle after the event.
// Backpressure: req_ready is zero while full or in reset; frees are always accepted.
module slot_alloc_arb
  import slot_alloc_arb_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter int          NUM_SLOTS = 16,
  parameter logic [63:0] BASE      = 64'd1,
  parameter logic [63:0] SLOT_SIZE = 64'd1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [63:0]                  rsp_addr,
  input  logic                         free_valid,
  input  logic [63:0]                  free_addr,
  output logic                         err_double_free,
  output logic                         err_range,
  output logic [$clog2(NUM_SLOTS):0]   used_count,
  output logic                         full,
  output logic                         empty
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(NUM_SLOTS) + 1;
  localparam int SH = $clog2(SLOT_SIZE);

  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [CW-1:0]        used_q, used_d;
  logic                 full_q, empty_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  addr_t                rsp_addr_q, alloc_addr;
  logic                 err_range_q, err_double_q;

  logic [NUM_REQ-1:0]   arb_req;
  logic                 grant;
  logic [SW-1:0]        alloc_idx;
  addr_t                free_off, free_slot64;
  logic [SW-1:0]        free_idx;
  logic [1:0]           free_err;
  logic                 free_ok;

  // Requests are hidden from the arbiter while full or in reset, so the
  // arbiter's grant is exactly req_ready and its pointer only moves on a grant.
  assign arb_req = req_valid & {NUM_REQ{!full_q && !reset}};
  assign grant   = |req_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock (clock),
    .reset (reset),
    .req_i (arb_req),
    .adv_i (grant),
    .gnt_o (req_ready)
  );

  // Lowest-index free slot: scanning downwards lets the lowest hit overwrite.
  // Uses the current bitmap, so a slot freed this cycle is not yet visible.
  always_comb begin
    alloc_idx = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!occ_q[k]) alloc_idx = SW'(k);
    end
  end

  assign alloc_addr = BASE + 64'(alloc_idx) * SLOT_SIZE;

  // Free decode: SLOT_SIZE is a power of two, so divide is a shift and the
  // alignment test is a mask of the low bits of the offset.
  always_comb begin
    free_off    = free_addr - BASE;
    free_slot64 = free_off >> SH;
    free_idx    = free_slot64[SW-1:0];
    free_err    = ERR_NONE;
    if (free_valid) begin
      if (free_addr < BASE || (free_off & (SLOT_SIZE - 64'd1)) != 64'd0 ||
          free_slot64 >= 64'(NUM_SLOTS)) begin
        free_err = ERR_RANGE;
      end else if (!occ_q[free_idx]) begin
        free_err = ERR_DOUBLE;
      end
    end
  end

  assign free_ok = free_valid && (free_err == ERR_NONE);

  // Grant and free never touch the same bit: the grant picks a free slot,
  // a valid free targets an occupied one.
  always_comb begin
    occ_d = occ_q;
    if (grant)   occ_d[alloc_idx] = 1'b1;
    if (free_ok) occ_d[free_idx]  = 1'b0;
    used_d = used_q + CW'(grant) - CW'(free_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q        <= '0;
      used_q       <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      rsp_valid_q  <= '0;
      rsp_addr_q   <= '0;
      err_range_q  <= 1'b0;
      err_double_q <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      used_q       <= used_d;
      full_q       <= (used_d == CW'(NUM_SLOTS));
      empty_q      <= (used_d == '0);
      rsp_valid_q  <= req_ready;
      if (grant) rsp_addr_q <= alloc_addr;
      err_range_q  <= (free_err == ERR_RANGE);
      err_double_q <= (free_err == ERR_DOUBLE);
    end
  end

  // Pulses are forced low while reset is held, including the cycle it rises.
  assign rsp_valid       = rsp_valid_q & {NUM_REQ{!reset}};
  assign rsp_addr        = rsp_addr_q;
  assign err_range       = err_range_q && !reset;
  assign err_double_free = err_double_q && !reset;
  assign used_count      = used_q;
  assign full            = full_q;
  assign empty           = empty_q;

endmodule

// File: tb/tb_slot_alloc_arb.sv
module tb_slot_alloc_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_addr;
  logic        free_valid;
  logic [63:0] free_addr;
  logic        err_double_free;
  logic        err_range;
  logic [4:0]  used_count;
  logic        full;
  logic        empty;

  int err_cnt = 0;
  int chk_cnt = 0;

  slot_alloc_arb dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_addr        (rsp_addr),
    .free_valid      (free_valid),
    .free_addr       (free_addr),
    .err_double_free (err_double_free),
    .err_range       (err_range),
    .used_count      (used_count),
    .full            (full),
    .empty           (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = 4'b0000;
    free_valid = 1'b0;
    free_addr  = 64'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with requests present to confirm req_ready stays low.
    reset      = 1'b1;
    req_valid  = 4'b1111;
    free_valid = 1'b0;
    free_addr  = 64'd0;
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_err_df", 64'(err_double_free), 64'h0);
    chk("rst_err_rng", 64'(err_range), 64'h0);
    chk("rst_used", 64'(used_count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_addr", rsp_addr, 64'h0);
    req_valid = 4'b0000;
    reset     = 1'b0;
    tick();

    // Single requester, three allocations.
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1 chk("s1_ready", 64'(req_ready), 64'h1);
      tick();
      chk("s1_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("s1_addr", rsp_addr, 64'(i + 1));
    end
    req_valid = 4'b0000;
    chk("s1_used", 64'(used_count), 64'd3);
    chk("s1_empty", 64'(empty), 64'd0);
    tick();
    chk("s1_rsp_idle", 64'(rsp_valid), 64'h0);
    chk("s1_addr_hold", rsp_addr, 64'h3);

    // All four requesting: strict rotation, ascending addresses.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 chk("s2_ready", 64'(req_ready), 64'(4'b0001 << (i % 4)));
      tick();
      chk("s2_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << (i % 4)));
      chk("s2_addr", rsp_addr, 64'(i + 1));
    end
    chk("s2_used", 64'(used_count), 64'd8);

    // Fill the remaining eight slots, then free 0x5 and reallocate it.
    req_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s3_addr", rsp_addr, 64'(i + 9));
    end
    chk("s3_full", 64'(full), 64'd1);
    chk("s3_used16", 64'(used_count), 64'd16);
    #1 chk("s3_ready_full", 64'(req_ready), 64'h0);
    free_valid = 1'b1;
    free_addr  = 64'h5;
    tick();
    free_valid = 1'b0;
    chk("s3_not_full", 64'(full), 64'd0);
    chk("s3_used15", 64'(used_count), 64'd15);
    #1 chk("s3_ready_again", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    chk("s3_realloc", rsp_addr, 64'h5);
    chk("s3_refull", 64'(full), 64'd1);

    // Double free of 0x3.
    free_valid = 1'b1;
    free_addr  = 64'h3;
    tick();
    chk("s4_first_df", 64'(err_double_free), 64'd0);
    chk("s4_used_a", 64'(used_count), 64'd15);
    tick();
    free_valid = 1'b0;
    chk("s4_second_df", 64'(err_double_free), 64'd1);
    chk("s4_used_b", 64'(used_count), 64'd15);
    tick();
    chk("s4_df_pulse_end", 64'(err_double_free), 64'd0);

    // Out-of-range frees: below BASE and one past the last slot.
    free_valid = 1'b1;
    free_addr  = 64'h0;
    tick();
    chk("s5_rng_low", 64'(err_range), 64'd1);
    chk("s5_low_no_df", 64'(err_double_free), 64'd0);
    free_addr = 64'h11;
    tick();
    free_valid = 1'b0;
    chk("s5_rng_high", 64'(err_range), 64'd1);
    chk("s5_used", 64'(used_count), 64'd15);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    chk("s5_rng_pulse_end", 64'(err_range), 64'd0);
    chk("s5_bitmap_intact", rsp_addr, 64'h3);
    chk("s5_full", 64'(full), 64'd1);

    // Simultaneous grant and free, then reset with a response pending.
    do_reset();
    req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    chk("s6_used4", 64'(used_count), 64'd4);
    free_valid = 1'b1;
    free_addr  = 64'h2;
    tick();
    free_valid = 1'b0;
    chk("s6_no_same_cycle", rsp_addr, 64'h5);
    chk("s6_used_same", 64'(used_count), 64'd4);
    tick();
    chk("s6_freed_next", rsp_addr, 64'h2);
    chk("s6_used5", 64'(used_count), 64'd5);
    reset = 1'b1;
    #1;
    chk("s6_rsp_dropped", 64'(rsp_valid), 64'h0);
    chk("s6_ready_rst", 64'(req_ready), 64'h0);
    tick();
    tick();
    chk("s6_rst_used", 64'(used_count), 64'd0);
    chk("s6_rst_empty", 64'(empty), 64'd1);
    chk("s6_rst_addr", rsp_addr, 64'h0);
    reset = 1'b0;
    #1 chk("s6_rearb_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    chk("s6_first_grant", rsp_addr, 64'h1);
    chk("s6_used1", 64'(used_count), 64'd1);
    chk("s6_not_empty", 64'(empty), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/slot_alloc_arb.md
SLOT_ALLOC_ARB -- requirements
Module: slot_alloc_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of allocation requesters.
REQ-002 The block SHALL have parameter NUM_SLOTS, default 16, the number of allocatable slots (power of two).
REQ-003 The block SHALL have parameter BASE, 64-bit, default 1, the address of slot 0.
REQ-004 The block SHALL have parameter SLOT_SIZE, 64-bit, default 1, the address stride between slots (power of two).
REQ-005 The block SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ, per-requester alloc request, held until accepted.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ, one-hot grant, combinational.
REQ-009 The block SHALL have port rsp_valid, output, NUM_REQ, one-hot registered allocation response.
REQ-010 The block SHALL have port rsp_addr, output, 64, the allocated address, valid with rsp_valid.
REQ-011 The block SHALL have port free_valid, input, 1, a free request, always accepted.
REQ-012 The block SHALL have port free_addr, input, 64, the address to free.
REQ-013 The block SHALL have port err_double_free, output, 1, a one-cycle pulse.
REQ-014 The block SHALL have port err_range, output, 1, a one-cycle pulse.
REQ-015 The block SHALL have outputs used_count (clog2(NUM_SLOTS)+1 bits), full (1) and empty (1).

Function
REQ-016 The block SHALL keep a NUM_SLOTS-bit occupancy bitmap; slot k maps to address BASE + k*SLOT_SIZE, computed modulo 2^64.
REQ-017 When not full, the block SHALL drive req_ready one-hot to the first valid requester at or after the round-robin pointer, wrapping at NUM_REQ.
REQ-018 When full, the block SHALL drive req_ready to all-zero.
REQ-019 On a grant, the block SHALL set the lowest-index free bit in the bitmap and advance the pointer to the granted index + 1 (mod NUM_REQ).
REQ-020 With no grant, the round-robin pointer SHALL be unchanged.
REQ-021 The block SHALL register the response one cycle after the grant: rsp_valid[i]=1 and rsp_addr set for exactly one cycle.
REQ-022 With no response, rsp_addr SHALL hold its last value.
REQ-023 A free request SHALL be decoded as slot = (free_addr - BASE)/SLOT_SIZE.
REQ-024 The block SHALL pulse err_range the next cycle, with no state change, if free_addr < BASE, is misaligned to SLOT_SIZE, or gives slot >= NUM_SLOTS.
REQ-025 The block SHALL pulse err_double_free the next cycle, with no state change, if the decoded slot is not occupied.
REQ-026 A valid free SHALL clear its bit at the clock edge.
REQ-027 A slot freed in cycle N SHALL NOT be granted in cycle N; it is eligible from cycle N+1.
REQ-028 When alloc and free occur in the same cycle, used_count SHALL be unchanged and full/empty SHALL be recomputed from the new bitmap.
REQ-029 The block SHALL register used_count, full (used_count==NUM_SLOTS) and empty (used_count==0), updated the cycle after the event.
REQ-030 At most one grant per cycle SHALL occur.

Reset
REQ-031 While reset is high, req_ready, rsp_valid, err_double_free and err_range SHALL be 0.
REQ-032 Reset SHALL set the bitmap and used_count to 0, full=0, empty=1, the pointer to 0 and rsp_addr to 0.
REQ-033 Reset asserted mid-operation SHALL discard pending responses and all allocations; in-flight requests SHALL be re-arbitrated after reset deasserts.

Structure
REQ-034 A shared package SHALL hold the 64-bit address typedef and the error-code constants.
REQ-035 One sub-module, rr_arbiter (parameterised N, request vector in, one-hot grant out, pointer register, advance enable), SHALL implement REQ-017, REQ-019 and REQ-020.
REQ-036 A lowest-free-slot priority encoder SHALL be implemented inline.

Verification
REQ-037 Scenario: reset, then req_valid=0001 for 3 cycles -> rsp_addr 0x1, 0x2, 0x3 on requester 0, and used_count=3.
REQ-038 Scenario: req_valid=1111 held 8 cycles -> grants in order 0,1,2,3,0,1,2,3; addresses 0x1..0x8 ascending.
REQ-039 Scenario: fill 16 slots -> full=1 and req_ready=0000 with req_valid=0001; then free 0x5 -> next grant returns 0x5.
REQ-040 Scenario: free 0x3 twice -> the second free pulses err_double_free and used_count decrements only once.
REQ-041 Scenario: free 0x0, then free 0x11 (BASE=1, 16 slots) -> err_range pulses for both, bitmap unchanged.
REQ-042 Scenario: with 4 slots used, a simultaneous grant and free of 0x2, then reset mid-stream -> used_count stays 4, 0x2 is not returned in the same cycle; after reset, empty=1 and the first grant returns 0x1.
